led_pattern_sequencer: RTL

//  Slot-mapped scheduler that drives the blinking LED core's slot interface as a bus master.

---
 rtl/led_pattern_sequencer_if.sv | 16 +
 rtl/led_pattern_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/led_pattern_sequencer_if.sv
// Slot bus between the CPU-side master and the LED pattern sequencer.
//   cs/read/write : select and strobes
//   addr          : word address (5 bits)
//   wr_data       : write data
//   rd_data       : combinational read data returned by the slave
interface led_pattern_sequencer_if;
  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  modport master (output cs, read, write, addr, wr_data, input rd_data);
  modport slave  (input cs, read, write, addr, wr_data, output rd_data);
endinterface

// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: a table of steps {led, interval, dwell_ms} is loaded over
// the slot bus, then a start walks the table, writing each interval into the LED
// core and holding for the dwell time before moving on. Optional looping.
// Ports:
//   clk, reset         : clock, async active-high reset
//   s                  : slot bus (slave side): CTRL@0, LEN@1, STAT@2, table@16+i
//   m_cs/m_write/m_addr/m_wr_data : one-cycle write to the LED core per step
//   busy               : run in progress
//   done_tick          : one-cycle pulse when a non-looping run completes
module led_pattern_sequencer #(
  parameter int DEPTH      = 16,
  parameter int CLK_PER_MS = 100000
) (
  input  logic                     clk,
  input  logic                     reset,
  led_pattern_sequencer_if.slave   s,
  output logic                     m_cs,
  output logic                     m_write,
  output logic [4:0]               m_addr,
  output logic [31:0]              m_wr_data,
  output logic                     busy,
  output logic                     done_tick
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_PER_MS - 1);

  typedef struct packed {
    logic [11:0] dwell;
    logic [1:0]  led;
    logic [15:0] interval;
  } entry_t;

  typedef enum logic [1:0] {IDLE, ISSUE, DWELL, NEXT} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] index_q, index_d;
  logic [4:0]    len_q, len_d;
  logic          loop_q, loop_d;
  logic          done_q, done_d;
  logic          done_tick_q, done_tick_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [11:0]   ms_q, ms_d;

  entry_t tbl_q [DEPTH];
  entry_t cur;
  logic   tbl_we;

  logic wr_en, ctrl_wr, start, stop, len_wr;
  logic unused_bits;

  assign wr_en   = s.cs & s.write;
  assign ctrl_wr = wr_en && (s.addr == 5'd0);
  assign start   = ctrl_wr & s.wr_data[0];
  assign stop    = ctrl_wr & s.wr_data[2];
  assign len_wr  = wr_en && (s.addr == 5'd1) && (state_q == IDLE);
  assign tbl_we  = wr_en && s.addr[4] && (state_q == IDLE) && (int'(s.addr[3:0]) < DEPTH);
  assign cur     = tbl_q[index_q];
  assign unused_bits = ^s.wr_data[31:30];

  // Table contents have no reset value; software reloads after reset.
  always_ff @(posedge clk) begin
    if (tbl_we) tbl_q[s.addr[IW-1:0]] <= entry_t'(s.wr_data[29:0]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      index_q     <= '0;
      len_q       <= '0;
      loop_q      <= 1'b0;
      done_q      <= 1'b0;
      done_tick_q <= 1'b0;
      pre_q       <= '0;
      ms_q        <= '0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      len_q       <= len_d;
      loop_q      <= loop_d;
      done_q      <= done_d;
      done_tick_q <= done_tick_d;
      pre_q       <= pre_d;
      ms_q        <= ms_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    len_d       = len_q;
    loop_d      = loop_q;
    done_d      = done_q;
    done_tick_d = 1'b0;
    pre_d       = pre_q;
    ms_d        = ms_q;

    if (len_wr) len_d = (s.wr_data[4:0] > 5'(DEPTH)) ? 5'(DEPTH) : s.wr_data[4:0];

    // Stop preempts every active state, so a finishing NEXT never sets done.
    if (stop && state_q != IDLE) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !stop && len_q != 5'd0) begin
            index_d = '0;
            done_d  = 1'b0;
            loop_d  = s.wr_data[1];
            state_d = ISSUE;
          end
        end
        ISSUE: begin
          pre_d   = '0;
          ms_d    = '0;
          state_d = DWELL;
        end
        DWELL: begin
          // ms_q counts whole milliseconds elapsed; zero dwell still spends one cycle here.
          if (cur.dwell == 12'd0 || (ms_q == cur.dwell - 12'd1 && pre_q == PRE_LAST)) begin
            state_d = NEXT;
          end else if (pre_q == PRE_LAST) begin
            pre_d = '0;
            ms_d  = ms_q + 12'd1;
          end else begin
            pre_d = pre_q + 1'b1;
          end
        end
        NEXT: begin
          if (5'(index_q) + 5'd1 < len_q) begin
            index_d = index_q + 1'b1;
            state_d = ISSUE;
          end else if (loop_q) begin
            index_d = '0;
            state_d = ISSUE;
          end else begin
            index_d     = '0;
            done_d      = 1'b1;
            done_tick_d = 1'b1;
            state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    m_cs      = 1'b0;
    m_write   = 1'b0;
    m_addr    = '0;
    m_wr_data = '0;
    if (state_q == ISSUE) begin
      m_cs      = 1'b1;
      m_write   = 1'b1;
      m_addr    = {3'b000, cur.led};
      m_wr_data = {16'h0000, cur.interval};
    end
  end

  assign busy      = (state_q != IDLE);
  assign done_tick = done_tick_q;

  always_comb begin
    s.rd_data = '0;
    if (s.cs && s.read && s.addr == 5'd2)
      s.rd_data = {19'b0, len_q, 4'(index_q), 1'b0, loop_q, done_q, busy};
  end
endmodule
